// File: rtl/shift_out_serializer.sv
// -----------------------------------------------------------------------------
// shift_out_serializer
//   Parallel-to-serial driver for a 74HC595-style shift/latch chain. One
//   WIDTH-bit word is accepted per load_valid/load_ready handshake and shifted
//   out MSB first on sdata/sclk, paced by the half-bit strobe "tick". Each word
//   ends with a single slatch pulse lasting one tick period, then a one-clock
//   done pulse.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-low reset
//   tick        in   half-bit-period enable strobe (1 clk wide)
//   load_valid  in   upstream offers load_data
//   load_data   in   word to transmit, sampled only on accept
//   load_ready  out  block can accept a word (IDLE)
//   busy        out  word in flight
//   sdata       out  serial data, MSB first, changes only while sclk is low
//   sclk        out  serial shift clock
//   slatch      out  storage-latch strobe after the last bit
//   done        out  1-clk pulse when the word is complete
//
// All outputs come straight from flops; there is no combinational path from
// any input to any output.
// -----------------------------------------------------------------------------
module shift_out_serializer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             busy,
    output logic             sdata,
    output logic             sclk,
    output logic             slatch,
    output logic             done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_HIGH  = 2'd2;
    localparam logic [1:0] ST_LATCH = 2'd3;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] shreg_q,  shreg_d;
    logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
    logic             sdata_q,  sdata_d;
    logic             sclk_q,   sclk_d;
    logic             slatch_q, slatch_d;
    logic             done_q,   done_d;
    logic             busy_q,   busy_d;
    logic             ready_q,  ready_d;

    // Next-state and next-output computation for the shift FSM.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        sdata_d  = sdata_q;
        sclk_d   = sclk_q;
        slatch_d = slatch_q;
        busy_d   = busy_q;
        ready_d  = ready_q;
        // done is a single-clock pulse: it falls on every edge it is not set.
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // tick is deliberately ignored here, so a tick on the accept
                // edge does not count towards the first half-bit.
                if (load_valid && ready_q) begin
                    shreg_d  = load_data;
                    sdata_d  = load_data[WIDTH-1];
                    bitcnt_d = CNT_W'(WIDTH - 1);
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = ST_SETUP;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    sclk_d  = 1'b1;
                    state_d = ST_HIGH;
                end else begin
                    state_d = ST_SETUP;
                end
            end
            ST_HIGH: begin
                if (tick) begin
                    sclk_d = 1'b0;
                    if (bitcnt_q == {CNT_W{1'b0}}) begin
                        slatch_d = 1'b1;
                        state_d  = ST_LATCH;
                    end else begin
                        // Next bit is presented together with the falling sclk
                        // so sdata never moves while sclk is high.
                        shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
                        sdata_d  = shreg_q[WIDTH-2];
                        bitcnt_d = bitcnt_q - CNT_W'(1);
                        state_d  = ST_SETUP;
                    end
                end else begin
                    state_d = ST_HIGH;
                end
            end
            ST_LATCH: begin
                if (tick) begin
                    slatch_d = 1'b0;
                    sdata_d  = 1'b0;
                    busy_d   = 1'b0;
                    ready_d  = 1'b1;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_LATCH;
                end
            end
            default: begin
                // Unreachable encoding: return to a clean idle condition.
                state_d  = ST_IDLE;
                shreg_d  = {WIDTH{1'b0}};
                bitcnt_d = {CNT_W{1'b0}};
                sdata_d  = 1'b0;
                sclk_d   = 1'b0;
                slatch_d = 1'b0;
                busy_d   = 1'b0;
                ready_d  = 1'b1;
            end
        endcase
    end

    // State and output registers; reset aborts any word in flight at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            shreg_q  <= {WIDTH{1'b0}};
            bitcnt_q <= {CNT_W{1'b0}};
            sdata_q  <= 1'b0;
            sclk_q   <= 1'b0;
            slatch_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            sdata_q  <= sdata_d;
            sclk_q   <= sclk_d;
            slatch_q <= slatch_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
        end
    end

    assign load_ready = ready_q;
    assign busy       = busy_q;
    assign sdata      = sdata_q;
    assign sclk       = sclk_q;
    assign slatch     = slatch_q;
    assign done       = done_q;

endmodule
